ps2_move_decoder: RTL and testbench

- Sits between the PS/2 keyboard receiver and the game core, in the CLOCK_50 domain.
- Consumes the receiver's raw scan-code bytes (received_data with its one-cycle received_data_en strobe).
- Produces a clean one-cycle move pulse with a registered 2-bit direction, which the game core uses.
- Parses make/break/extended prefixes, suppresses typematic auto-repeat, and enforces a post-move cooldown so the game animation is not flooded.

---
 rtl/ps2_move_decoder_pkg.sv | 61 ++++++
 rtl/ps2_move_cooldown.sv | 37 +++
 rtl/ps2_move_decoder.sv | 136 +++++++++++++
 tb/tb_ps2_move_decoder.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_move_decoder_pkg.sv
// Shared scan-code constants, direction encodings and parser state encoding
// for the PS/2 move decoder.
package ps2_move_decoder_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;

  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam logic [1:0] DIR_TL = 2'b11;
  localparam logic [1:0] DIR_BL = 2'b01;
  localparam logic [1:0] DIR_BR = 2'b00;
  localparam logic [1:0] DIR_TR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

  typedef struct packed {
    logic       hit;
    logic [1:0] dir;
  } key_dec_t;

  function automatic key_dec_t decode_plain(input logic [7:0] code);
    key_dec_t r;
    r = '0;
    case (code)
      SC_W:    r = '{hit: 1'b1, dir: DIR_TL};
      SC_A:    r = '{hit: 1'b1, dir: DIR_BL};
      SC_S:    r = '{hit: 1'b1, dir: DIR_BR};
      SC_D:    r = '{hit: 1'b1, dir: DIR_TR};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic key_dec_t decode_arrow(input logic [7:0] code);
    key_dec_t r;
    r = '0;
    case (code)
      SC_UP:    r = '{hit: 1'b1, dir: DIR_TL};
      SC_LEFT:  r = '{hit: 1'b1, dir: DIR_BL};
      SC_DOWN:  r = '{hit: 1'b1, dir: DIR_BR};
      SC_RIGHT: r = '{hit: 1'b1, dir: DIR_TR};
      default:  r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_move_cooldown.sv
// Saturating down-counter that blanks new moves for COOLDOWN_CYCLES clocks
// after each accepted move.
module ps2_move_cooldown #(
  parameter int COOLDOWN_CYCLES = 2500000,
  parameter int CNT_W           = 22
) (
  input  logic clock,
  input  logic resetn,
  input  logic load,
  output logic busy,
  output logic zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(COOLDOWN_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);
  assign busy = ~zero;

endmodule

// File: rtl/ps2_move_decoder.sv
// PS/2 scan-code parser turning WASD (and, with PS2_ARROW_KEYS_EN defined,
// extended arrow keys) into rate-limited one-cycle move pulses.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | no prefix pending; next byte is a plain make
// ST_EXT     | E0 seen; next byte is an extended make
// ST_BRK     | F0 seen; next byte is a plain break
// ST_EXT_BRK | E0 F0 seen; next byte is an extended break
module ps2_move_decoder
  import ps2_move_decoder_pkg::*;
#(
  parameter int COOLDOWN_CYCLES = 2500000,
  parameter int CNT_W           = 22
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] data,
  input  logic       data_en,
  output logic       move,
  output logic [1:0] dir,
  output logic       key_held,
  output logic       busy
);

  ps2_state_e state_q, state_d;
  logic       move_q, move_d;
  logic [1:0] dir_q, dir_d;
  logic       key_held_q, key_held_d;
  logic [1:0] held_dir_q, held_dir_d;

  key_dec_t   make_dec;
  key_dec_t   brk_dec;
  logic       cd_load;
  logic       cd_busy;
  logic       cd_zero;
  logic       is_repeat;

  ps2_move_cooldown #(
    .COOLDOWN_CYCLES(COOLDOWN_CYCLES),
    .CNT_W          (CNT_W)
  ) u_cooldown (
    .clock (clock),
    .resetn(resetn),
    .load  (cd_load),
    .busy  (cd_busy),
    .zero  (cd_zero)
  );

  always_comb begin
    state_d    = state_q;
    move_d     = 1'b0;
    dir_d      = dir_q;
    key_held_d = key_held_q;
    held_dir_d = held_dir_q;
    cd_load    = 1'b0;
    make_dec   = '0;
    brk_dec    = '0;
    is_repeat  = 1'b0;

    if (data_en) begin
      case (state_q)
        ST_IDLE: begin
          if (data == SC_BREAK) begin
            state_d = ST_BRK;
          end else if (data == SC_EXT) begin
            state_d = ST_EXT;
          end else begin
            make_dec = decode_plain(data);
          end
        end
        ST_EXT: begin
          if (data == SC_BREAK) begin
            state_d = ST_EXT_BRK;
          end else if (data != SC_EXT) begin
            state_d = ST_IDLE;
`ifdef PS2_ARROW_KEYS_EN
            make_dec = decode_arrow(data);
`endif
          end
        end
        ST_BRK: begin
          if (data != SC_BREAK) begin
            state_d = ST_IDLE;
            brk_dec = decode_plain(data);
          end
        end
        ST_EXT_BRK: begin
          if (data != SC_BREAK) begin
            state_d = ST_IDLE;
`ifdef PS2_ARROW_KEYS_EN
            brk_dec = decode_arrow(data);
`endif
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A held key's own make is typematic repeat; anything else needs an idle cooldown.
    is_repeat = key_held_q && (held_dir_q == make_dec.dir);
    if (make_dec.hit && !is_repeat && cd_zero) begin
      move_d     = 1'b1;
      dir_d      = make_dec.dir;
      held_dir_d = make_dec.dir;
      key_held_d = 1'b1;
      cd_load    = 1'b1;
    end

    if (brk_dec.hit && key_held_q && (held_dir_q == brk_dec.dir)) begin
      key_held_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      move_q     <= 1'b0;
      dir_q      <= 2'b00;
      key_held_q <= 1'b0;
      held_dir_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      move_q     <= move_d;
      dir_q      <= dir_d;
      key_held_q <= key_held_d;
      held_dir_q <= held_dir_d;
    end
  end

  assign move     = move_q;
  assign dir      = dir_q;
  assign key_held = key_held_q;
  assign busy     = cd_busy;

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Directed self-checking bench for ps2_move_decoder with a 16-cycle cooldown.
module tb_ps2_move_decoder;

  logic       clock;
  logic       resetn;
  logic [7:0] data;
  logic       data_en;
  logic       move;
  logic [1:0] dir;
  logic       key_held;
  logic       busy;

  int vectors;
  int errors;
  int move_cnt;
  int m0;

  ps2_move_decoder #(
    .COOLDOWN_CYCLES(16),
    .CNT_W          (5)
  ) dut (
    .clock   (clock),
    .resetn  (resetn),
    .data    (data),
    .data_en (data_en),
    .move    (move),
    .dir     (dir),
    .key_held(key_held),
    .busy    (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (move === 1'b1) move_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Returns 1 ns after the edge that captured the byte: move shows its result now.
  task automatic send_byte(input logic [7:0] b);
    @(posedge clock);
    #1;
    data    = b;
    data_en = 1'b1;
    @(posedge clock);
    #1;
    data_en = 1'b0;
    data    = 8'h00;
  endtask

  task automatic send_pair(input logic [7:0] b0, input logic [7:0] b1);
    @(posedge clock);
    #1;
    data    = b0;
    data_en = 1'b1;
    @(posedge clock);
    #1;
    data    = b1;
    @(posedge clock);
    #1;
    data_en = 1'b0;
    data    = 8'h00;
  endtask

  task automatic do_reset();
    data_en = 1'b0;
    data    = 8'h00;
    resetn  = 1'b0;
    idle(2);
    resetn  = 1'b1;
    idle(1);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({move, dir, key_held, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got move=%b dir=%b held=%b busy=%b want all 0", move, dir, key_held, busy);
    end
  endtask

  task automatic test_single_make();
    do_reset();
    send_byte(8'h1D);
    vectors++;
    if ({move, dir, key_held, busy} !== 5'b1_11_1_1) begin
      errors++;
      $display("FAIL w_make: got move=%b dir=%b held=%b busy=%b want 1 11 1 1", move, dir, key_held, busy);
    end
    idle(1);
    vectors++;
    if (move !== 1'b0) begin
      errors++;
      $display("FAIL w_pulse_width: got move=%b want 0", move);
    end
    idle(14);
    vectors++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_last_cycle: got %b want 1", busy);
    end
    idle(1);
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_end: got %b want 0", busy);
    end
  endtask

  task automatic test_typematic();
    do_reset();
    m0 = move_cnt;
    send_byte(8'h1D);
    idle(20);
    send_byte(8'h1D);
    send_byte(8'h1D);
    idle(2);
    vectors++;
    if (move_cnt - m0 !== 1) begin
      errors++;
      $display("FAIL typematic_count: got %0d moves want 1", move_cnt - m0);
    end
    send_byte(8'hF0);
    send_byte(8'h1D);
    vectors++;
    if ({move, key_held} !== 2'b00) begin
      errors++;
      $display("FAIL w_break: got move=%b held=%b want 0 0", move, key_held);
    end
    send_byte(8'h1D);
    vectors++;
    if ({move, dir, key_held} !== 4'b1_11_1) begin
      errors++;
      $display("FAIL w_remake: got move=%b dir=%b held=%b want 1 11 1", move, dir, key_held);
    end
  endtask

  task automatic test_cooldown_drop();
    do_reset();
    send_byte(8'h1C);
    vectors++;
    if ({move, dir} !== 3'b1_01) begin
      errors++;
      $display("FAIL a_make: got move=%b dir=%b want 1 01", move, dir);
    end
    idle(4);
    send_byte(8'h23);
    vectors++;
    if ({move, dir, key_held} !== 4'b0_01_1) begin
      errors++;
      $display("FAIL d_dropped: got move=%b dir=%b held=%b want 0 01 1", move, dir, key_held);
    end
    idle(20);
    send_byte(8'h23);
    vectors++;
    if ({move, dir} !== 3'b1_10) begin
      errors++;
      $display("FAIL d_retry: got move=%b dir=%b want 1 10", move, dir);
    end
  endtask

  task automatic test_break_other();
    idle(20);
    send_byte(8'hF0);
    send_byte(8'h1B);
    vectors++;
    if ({move, dir, key_held} !== 4'b0_10_1) begin
      errors++;
      $display("FAIL s_break_ignored: got move=%b dir=%b held=%b want 0 10 1", move, dir, key_held);
    end
    send_byte(8'h1B);
    vectors++;
    if ({move, dir} !== 3'b1_00) begin
      errors++;
      $display("FAIL s_make: got move=%b dir=%b want 1 00", move, dir);
    end
  endtask

  task automatic test_cooldown_edge();
    do_reset();
    send_byte(8'h1C);
    idle(14);
    send_byte(8'h23);
    vectors++;
    if ({move, busy} !== 2'b00) begin
      errors++;
      $display("FAIL edge_count1_drop: got move=%b busy=%b want 0 0", move, busy);
    end
    do_reset();
    send_byte(8'h1C);
    idle(15);
    send_byte(8'h23);
    vectors++;
    if ({move, dir} !== 3'b1_10) begin
      errors++;
      $display("FAIL edge_count0_accept: got move=%b dir=%b want 1 10", move, dir);
    end
  endtask

  task automatic test_extended();
    do_reset();
    send_byte(8'hE0);
    send_byte(8'h75);
`ifdef PS2_ARROW_KEYS_EN
    vectors++;
    if ({move, dir, key_held} !== 4'b1_11_1) begin
      errors++;
      $display("FAIL up_make: got move=%b dir=%b held=%b want 1 11 1", move, dir, key_held);
    end
`else
    vectors++;
    if ({move, dir, key_held} !== 4'b0_00_0) begin
      errors++;
      $display("FAIL up_ignored: got move=%b dir=%b held=%b want 0 00 0", move, dir, key_held);
    end
`endif
    idle(20);
    m0 = move_cnt;
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    idle(2);
    vectors++;
    if ((move_cnt - m0 !== 0) || (key_held !== 1'b0)) begin
      errors++;
      $display("FAIL up_break: got moves=%0d held=%b want 0 0", move_cnt - m0, key_held);
    end
    send_byte(8'h1B);
    vectors++;
    if ({move, dir} !== 3'b1_00) begin
      errors++;
      $display("FAIL after_ext_idle: got move=%b dir=%b want 1 00", move, dir);
    end
  endtask

  task automatic test_reset_mid_prefix();
    do_reset();
    send_byte(8'h1D);
    send_byte(8'hE0);
    @(posedge clock);
    #1;
    resetn = 1'b0;
    #1;
    vectors++;
    if ({move, dir, key_held, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_async: got move=%b dir=%b held=%b busy=%b want all 0", move, dir, key_held, busy);
    end
    idle(2);
    vectors++;
    if ({move, dir, key_held, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_hold: got move=%b dir=%b held=%b busy=%b want all 0", move, dir, key_held, busy);
    end
    resetn = 1'b1;
    send_byte(8'h23);
    vectors++;
    if ({move, dir} !== 3'b1_10) begin
      errors++;
      $display("FAIL prefix_discard: got move=%b dir=%b want 1 10", move, dir);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    m0 = move_cnt;
    send_pair(8'h1C, 8'h1B);
    idle(2);
    vectors++;
    if ((move_cnt - m0 !== 1) || (dir !== 2'b01)) begin
      errors++;
      $display("FAIL b2b_makes: got moves=%0d dir=%b want 1 01", move_cnt - m0, dir);
    end
    idle(20);
    send_pair(8'hF0, 8'h1C);
    vectors++;
    if (key_held !== 1'b0) begin
      errors++;
      $display("FAIL b2b_break: got held=%b want 0", key_held);
    end
    send_pair(8'hE0, 8'h23);
    idle(1);
    vectors++;
    if (key_held !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ext_plain: got held=%b want 0", key_held);
    end
  endtask

  initial begin
    vectors  = 0;
    errors   = 0;
    move_cnt = 0;
    resetn   = 1'b0;
    data     = 8'h00;
    data_en  = 1'b0;
    test_reset();
    test_single_make();
    test_typematic();
    test_cooldown_drop();
    test_break_other();
    test_cooldown_edge();
    test_extended();
    test_reset_mid_prefix();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
